// File: rtl/pixie_vram_arbiter.sv
// pixie_vram_arbiter: shares one 1024x8 video RAM port between the Pixie DMA
// write stream, the scan-out reader, the host/debug port and a clear sequencer.
// DMA always wins (it is registered one cycle and can never stall). The host
// is promoted above scan once it has waited HOST_MAX_WAIT cycles. The clear
// sequencer only uses cycles that nobody else wants.
module pixie_vram_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 8,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_data,
  input  logic              dma_wr,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

  localparam logic [7:0]        HOST_LIMIT = 8'(HOST_MAX_WAIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  logic              dma_pend;
  logic [ADDR_W-1:0] dma_pend_addr;
  logic [DATA_W-1:0] dma_pend_data;
  logic              scan_gnt_reg;   // scan granted last cycle: read in flight
  logic              host_gnt_reg;   // host granted last cycle
  logic              host_rd_reg;    // host read in flight
  logic [7:0]        host_wait;
  clr_state_t        clr_state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] ram_addr_hold;

  logic gnt_dma, gnt_host, gnt_scan, gnt_clr;
  logic scan_ok, host_ok;

  // A requester is ineligible only in the cycle right after its own grant.
  assign scan_ok = scan_req && !scan_gnt_reg;
  assign host_ok = host_req && !host_gnt_reg;

  // Fixed-priority grant; nothing is granted while reset is held so a pending
  // DMA byte or a running clear cannot touch the RAM during reset.
  always_comb begin
    gnt_dma  = 1'b0;
    gnt_host = 1'b0;
    gnt_scan = 1'b0;
    gnt_clr  = 1'b0;
    if (!reset) begin
      if (dma_pend)                               gnt_dma  = 1'b1;
      else if (host_ok && host_wait >= HOST_LIMIT) gnt_host = 1'b1;
      else if (scan_ok)                           gnt_scan = 1'b1;
      else if (host_ok)                           gnt_host = 1'b1;
      else if (clr_state == CLR_RUN)              gnt_clr  = 1'b1;
    end
  end

  // Drive the RAM port from the winner; the address parks on its last value.
  always_comb begin
    ram_addr  = ram_addr_hold;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (gnt_dma) begin
      ram_addr  = dma_pend_addr;
      ram_we    = 1'b1;
      ram_wdata = dma_pend_data;
    end else if (gnt_host) begin
      ram_addr  = host_addr;
      ram_we    = host_we;
      ram_wdata = host_we ? host_wdata : '0;
    end else if (gnt_scan) begin
      ram_addr  = scan_addr;
    end else if (gnt_clr) begin
      ram_addr  = clr_ptr;
      ram_we    = 1'b1;
    end
  end

  // DMA stage: capture every strobe unconditionally.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_pend      <= 1'b0;
      dma_pend_addr <= '0;
      dma_pend_data <= '0;
    end else begin
      dma_pend      <= dma_wr;
      dma_pend_addr <= dma_addr;
      dma_pend_data <= dma_data;
    end
  end

  // Remember the last address presented so idle cycles keep it stable.
  always_ff @(posedge clk) begin
    if (reset)
      ram_addr_hold <= '0;
    else if (gnt_dma || gnt_host || gnt_scan || gnt_clr)
      ram_addr_hold <= ram_addr;
  end

  // Scan read return: RAM data arrives one cycle after grant, valid the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_gnt_reg <= 1'b0;
      scan_valid   <= 1'b0;
      scan_data    <= '0;
    end else begin
      scan_gnt_reg <= gnt_scan;
      scan_valid   <= scan_gnt_reg;
      if (scan_gnt_reg)
        scan_data <= ram_rdata;
    end
  end

  // Host completion: writes ack the cycle after grant, reads one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_gnt_reg <= 1'b0;
      host_rd_reg  <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
    end else begin
      host_gnt_reg <= gnt_host;
      host_rd_reg  <= gnt_host && !host_we;
      host_ack     <= (gnt_host && host_we) || host_rd_reg;
      if (host_rd_reg)
        host_rdata <= ram_rdata;
    end
  end

  // Host starvation counter: counts lost cycles, saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset)
      host_wait <= '0;
    else if (gnt_host)
      host_wait <= '0;
    else if (host_req && host_wait < HOST_LIMIT)
      host_wait <= host_wait + 8'd1;
  end

  // Clear sequencer: one zero write per granted cycle, single pass, then done.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state <= CLR_IDLE;
      clr_ptr   <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (clr_state)
        CLR_IDLE: begin
          if (clr_start) begin
            clr_ptr   <= '0;
            clr_state <= CLR_RUN;
            clr_busy  <= 1'b1;
          end
        end
        CLR_RUN: begin
          if (gnt_clr) begin
            if (clr_ptr == LAST_ADDR) begin
              clr_state <= CLR_IDLE;
              clr_busy  <= 1'b0;
              clr_done  <= 1'b1;
            end else begin
              clr_ptr <= clr_ptr + ADDR_W'(1);
            end
          end
        end
        default: clr_state <= CLR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixie_vram_arbiter.sv
// Directed bench for pixie_vram_arbiter with a behavioural 1024x8 RAM.
module tb_pixie_vram_arbiter;

  logic       clk;
  logic       reset;
  logic [9:0] dma_addr;
  logic [7:0] dma_data;
  logic       dma_wr;
  logic       scan_req;
  logic [9:0] scan_addr;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       host_req;
  logic       host_we;
  logic [9:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       clr_start;
  logic       clr_busy;
  logic       clr_done;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  logic [7:0] mem [0:1023];
  logic       bd_fill;
  logic       bd_we;
  logic [9:0] bd_addr;
  logic [7:0] bd_data;

  int total = 0;
  int bad   = 0;

  pixie_vram_arbiter #(.ADDR_W(10), .DATA_W(8), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .dma_addr(dma_addr), .dma_data(dma_data), .dma_wr(dma_wr),
    .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_valid(scan_valid), .scan_data(scan_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with registered read, plus backdoor fill/poke for preloading
  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'hFF;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    nxt();
    bd_we = 1'b0;
  endtask

  task automatic fill_ff();
    bd_fill = 1'b1;
    nxt();
    bd_fill = 1'b0;
  endtask

  initial begin
    int busy_n, done_n, done_at, nz, ff_n, evt;
    reset = 1'b1; dma_wr = 0; dma_addr = 0; dma_data = 0;
    scan_req = 0; scan_addr = 0; host_req = 0; host_we = 0;
    host_addr = 0; host_wdata = 0; clr_start = 0;
    bd_fill = 0; bd_we = 0; bd_addr = 0; bd_data = 0;
    fill_ff();
    repeat (2) nxt();
    #2;
    chk("rst_scan_valid", 32'(scan_valid), 0);
    chk("rst_host_ack",   32'(host_ack), 0);
    chk("rst_clr",        {30'd0, clr_busy, clr_done}, 0);
    chk("rst_ram",        {21'd0, ram_we, ram_addr}, 0);
    chk("rst_data",       {16'd0, scan_data, host_rdata}, 0);
    nxt(); reset = 1'b0;

    // preloads
    poke(10'h123, 8'h5A);
    poke(10'h200, 8'h11);
    poke(10'h300, 8'h22);

    // DMA stream, 8 back-to-back strobes
    for (int i = 0; i <= 8; i++) begin
      nxt();
      if (i < 8) begin
        dma_wr = 1; dma_addr = 10'h050 + 10'(i); dma_data = 8'hA0 + 8'(i);
      end else begin
        dma_wr = 0;
      end
      #2;
      if (i > 0) begin
        chk("dma_we",   32'(ram_we), 1);
        chk("dma_addr", 32'(ram_addr), 32'h050 + 32'(i - 1));
        chk("dma_data", 32'(ram_wdata), 32'hA0 + 32'(i - 1));
      end
    end
    nxt(); #2;
    chk("dma_idle_we", 32'(ram_we), 0);
    chk("dma_mem_57", 32'(mem[10'h057]), 32'hA7);

    // single scan read
    nxt(); scan_req = 1; scan_addr = 10'h123; #2;
    chk("scan_gnt_addr", 32'(ram_addr), 32'h123);
    chk("scan_gnt_we", 32'(ram_we), 0);
    nxt(); #2;
    chk("scan_n1_valid", 32'(scan_valid), 0);
    nxt(); scan_req = 0; #2;
    chk("scan_n2_valid", 32'(scan_valid), 1);
    chk("scan_n2_data", 32'(scan_data), 32'h5A);
    nxt(); #2;
    chk("scan_pulse_end", 32'(scan_valid), 0);

    // priority: DMA, then scan, then host
    nxt(); dma_wr = 1; dma_addr = 10'h010; dma_data = 8'h33; #2;
    nxt(); dma_wr = 0;
    scan_req = 1; scan_addr = 10'h200;
    host_req = 1; host_we = 0; host_addr = 10'h300; #2;
    chk("pri_dma", {23'd0, ram_we, ram_wdata}, {23'd0, 1'b1, 8'h33});
    chk("pri_dma_addr", 32'(ram_addr), 32'h010);
    nxt(); #2;
    chk("pri_scan_addr", 32'(ram_addr), 32'h200);
    nxt(); #2;
    chk("pri_host_addr", 32'(ram_addr), 32'h300);
    nxt(); scan_req = 0; host_req = 0; #2;
    chk("pri_scan_valid", 32'(scan_valid), 1);
    chk("pri_scan_data", 32'(scan_data), 32'h11);
    chk("pri_host_ack_early", 32'(host_ack), 0);
    nxt(); #2;
    chk("pri_host_ack", 32'(host_ack), 1);
    chk("pri_host_data", 32'(host_rdata), 32'h22);
    chk("pri_scan_pulse", 32'(scan_valid), 0);
    nxt(); #2;
    chk("pri_host_pulse", 32'(host_ack), 0);
    chk("pri_mem_010", 32'(mem[10'h010]), 32'h33);

    // scan and host together: host gets the slot after scan's grant
    nxt(); scan_req = 1; scan_addr = 10'h123;
    host_req = 1; host_we = 0; host_addr = 10'h300; #2;
    chk("alt_scan_addr", 32'(ram_addr), 32'h123);
    nxt(); #2;
    chk("alt_host_addr", 32'(ram_addr), 32'h300);
    nxt(); scan_req = 0; host_req = 0; #2;
    chk("alt_scan_data", {23'd0, scan_valid, scan_data}, {23'd0, 1'b1, 8'h5A});
    nxt(); #2;
    chk("alt_host_data", {23'd0, host_ack, host_rdata}, {23'd0, 1'b1, 8'h22});

    // host promotion after losing 4 cycles to a DMA stream
    for (int i = 0; i < 6; i++) begin
      nxt(); dma_wr = 1; dma_addr = 10'h060 + 10'(i); dma_data = 8'hC0 + 8'(i);
      if (i == 1) begin
        scan_req = 1; scan_addr = 10'h123;
        host_req = 1; host_we = 0; host_addr = 10'h300;
      end
    end
    nxt(); dma_wr = 0; #2;
    chk("promo_dma_last", {21'd0, ram_we, ram_addr}, {21'd0, 1'b1, 10'h065});
    nxt(); #2;
    chk("promo_host_first", 32'(ram_addr), 32'h300);
    nxt(); #2;
    chk("promo_scan_next", 32'(ram_addr), 32'h123);
    nxt(); host_req = 0; scan_req = 0; #2;
    chk("promo_host_ack", {23'd0, host_ack, host_rdata}, {23'd0, 1'b1, 8'h22});
    nxt(); #2;
    chk("promo_scan_valid", {23'd0, scan_valid, scan_data}, {23'd0, 1'b1, 8'h5A});
    chk("promo_host_pulse", 32'(host_ack), 0);

    // host write
    nxt(); host_req = 1; host_we = 1; host_addr = 10'h0AA; host_wdata = 8'h77; #2;
    chk("hw_we", {22'd0, ram_we, ram_wdata, host_ack}, {22'd0, 1'b1, 8'h77, 1'b0});
    chk("hw_addr", 32'(ram_addr), 32'h0AA);
    nxt(); host_req = 0; host_we = 0; #2;
    chk("hw_ack", 32'(host_ack), 1);
    nxt(); #2;
    chk("hw_ack_pulse", 32'(host_ack), 0);
    chk("hw_mem", 32'(mem[10'h0AA]), 32'h77);

    // full clear with a second ignored clr_start
    fill_ff();
    clr_start = 1; #2;
    chk("clr_busy_n0", 32'(clr_busy), 0);
    nxt(); clr_start = 0; #2;
    chk("clr_busy_n1", 32'(clr_busy), 1);
    chk("clr_first_wr", {13'd0, ram_we, ram_addr, ram_wdata}, {13'd0, 1'b1, 10'h000, 8'h00});
    busy_n = 1; done_n = 0; done_at = 0;
    for (int k = 2; k <= 1030; k++) begin
      nxt(); clr_start = (k == 100); #2;
      if (clr_busy) busy_n++;
      if (clr_done) begin done_n++; done_at = k; end
    end
    clr_start = 0;
    chk("clr_busy_cycles", 32'(busy_n), 1024);
    chk("clr_done_count", 32'(done_n), 1);
    chk("clr_done_at", 32'(done_at), 1025);
    nz = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != 8'h00) nz++;
    chk("clr_nonzero", 32'(nz), 0);

    // reset mid-clear with a host read in flight
    fill_ff();
    clr_start = 1;
    nxt(); clr_start = 0;
    for (int k = 2; k <= 512; k++) nxt();
    #2;
    chk("rc_ptr_1ff", {21'd0, ram_we, ram_addr}, {21'd0, 1'b1, 10'h1FF});
    nxt(); host_req = 1; host_we = 0; host_addr = 10'h300; #2;
    chk("rc_host_gnt", {21'd0, ram_we, ram_addr}, {21'd0, 1'b0, 10'h300});
    nxt(); host_req = 0; reset = 1; #2;
    chk("rc_no_write", 32'(ram_we), 0);
    nxt(); reset = 0; #2;
    chk("rc_busy", 32'(clr_busy), 0);
    chk("rc_ack", 32'(host_ack), 0);
    chk("rc_rdata", 32'(host_rdata), 0);
    evt = 0;
    for (int k = 0; k < 4; k++) begin
      nxt(); #2;
      if (host_ack || clr_done || clr_busy) evt++;
    end
    chk("rc_quiet", 32'(evt), 0);
    ff_n = 0;
    for (int i = 10'h200; i < 1024; i++) if (mem[i] == 8'hFF) ff_n++;
    chk("rc_tail_ff", 32'(ff_n), 512);
    chk("rc_mem_1ff", 32'(mem[10'h1FF]), 0);
    chk("rc_mem_000", 32'(mem[10'h000]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
